// File: rtl/core_pkg.sv
// Shared definitions for the operand-forwarding controller: select encodings,
// FSM state codes and the EX/MEM stage-record types.
package core_pkg;

  localparam int REG_AW = 5;

  localparam logic [1:0] OPSEL_REG   = 2'b00;
  localparam logic [1:0] OPSEL_EXMEM = 2'b01;
  localparam logic [1:0] OPSEL_MEMWB = 2'b10;
  localparam logic [1:0] OPSEL_ALT   = 2'b11;

  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_STALL = 1'b1;

  typedef struct packed {
    logic              vld;
    logic [REG_AW-1:0] rd;
    logic              wr;
    logic              ld;
  } ex_rec_t;

  typedef struct packed {
    logic              vld;
    logic [REG_AW-1:0] rd;
    logic              wr;
  } mem_rec_t;

  function automatic mem_rec_t ex_to_mem(input ex_rec_t e);
    mem_rec_t m;
    m.vld = e.vld;
    m.rd  = e.rd;
    m.wr  = e.wr;
    return m;
  endfunction

  // Priority: override, then youngest producer (EX), then MEM, else regfile.
  function automatic logic [1:0] pick_sel(input logic alt, input logic hit_ex,
                                          input logic hit_mem, input logic fwd_en);
    if (alt)                 return OPSEL_ALT;
    if (fwd_en && hit_ex)    return OPSEL_EXMEM;
    if (fwd_en && hit_mem)   return OPSEL_MEMWB;
    return OPSEL_REG;
  endfunction

endpackage

// File: rtl/alu_operand_ctrl_if.sv
// ID-stage request / EX-stage select bundle between the pipeline and the
// operand-forwarding controller.
interface alu_operand_ctrl_if #(
  parameter int REGADDR_WIDTH = 5,
  parameter int DATA_WIDTH    = 32
);
  logic                     id_valid;
  logic [REGADDR_WIDTH-1:0] id_rs1;
  logic [REGADDR_WIDTH-1:0] id_rs2;
  logic                     id_use_rs1;
  logic                     id_use_rs2;
  logic [REGADDR_WIDTH-1:0] id_rd;
  logic                     id_reg_write;
  logic                     id_mem_read;
  logic                     id_a_pc;
  logic                     id_b_imm;
  logic                     flush;
  logic                     stall;
  logic                     ex_bubble;
  logic [1:0]               fwd_a_sel;
  logic [1:0]               fwd_b_sel;
  logic [DATA_WIDTH-1:0]    stall_count;

  modport master (
    output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd,
           id_reg_write, id_mem_read, id_a_pc, id_b_imm, flush,
    input  stall, ex_bubble, fwd_a_sel, fwd_b_sel, stall_count
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd,
           id_reg_write, id_mem_read, id_a_pc, id_b_imm, flush,
    output stall, ex_bubble, fwd_a_sel, fwd_b_sel, stall_count
  );
endinterface

// File: rtl/alu_operand_ctrl_raw_match.sv
// Combinational RAW comparator: does a source operand read the register a
// stage record is going to write? x0 never matches.
module raw_match
  import core_pkg::*;
(
  input  logic [REG_AW-1:0] rs_i,
  input  logic              use_i,
  input  mem_rec_t          rec_i,
  output logic              hit_o
);

  assign hit_o = use_i & rec_i.vld & rec_i.wr & (rec_i.rd == rs_i) & (rs_i != '0);

endmodule

// File: rtl/alu_operand_ctrl.sv
// Hazard/forwarding controller for the EX-stage ALU operand muxes.
// Define ALU_FWD_EN to enable EX/MEM and MEM/WB forwarding; otherwise RAW hazards stall.
module alu_operand_ctrl
  import core_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int REGADDR_WIDTH = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  alu_operand_ctrl_if.slave bus
);

`ifdef ALU_FWD_EN
  localparam logic FWD_EN = 1'b1;
`else
  localparam logic FWD_EN = 1'b0;
`endif

  ex_rec_t               ex_q, ex_d;
  mem_rec_t              mem_q;
  logic [0:0]            state_q, state_d;
  logic [1:0]            sel_a_q, sel_a_d, sel_b_q, sel_b_d;
  logic                  bubble_q;
  logic [DATA_WIDTH-1:0] count_q;

  logic [REGADDR_WIDTH-1:0] src_rs  [2];
  logic                     src_use [2];
  mem_rec_t                 rec     [2];
  logic [3:0]               hit;
  logic                     hazard, stall, advance;

  // An operand override replaces the register read, so it cannot create a hazard.
  assign src_rs[0]  = bus.id_rs1;
  assign src_rs[1]  = bus.id_rs2;
  assign src_use[0] = bus.id_use_rs1 & ~bus.id_a_pc;
  assign src_use[1] = bus.id_use_rs2 & ~bus.id_b_imm;
  assign rec[0]     = ex_to_mem(ex_q);
  assign rec[1]     = mem_q;

  // hit[0]/hit[1]: rs1/rs2 against EX; hit[2]/hit[3]: rs1/rs2 against MEM.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_match
      raw_match u_match (
        .rs_i  (src_rs[gi % 2]),
        .use_i (src_use[gi % 2]),
        .rec_i (rec[gi / 2]),
        .hit_o (hit[gi])
      );
    end
  endgenerate

`ifdef ALU_FWD_EN
  // Only a load in EX cannot be forwarded in time; the state gate caps the stall at one cycle.
  assign hazard = ex_q.ld & (hit[0] | hit[1]) & (state_q == ST_RUN);
`else
  assign hazard = |hit;
  logic state_unused;
  assign state_unused = state_q[0];
`endif

  assign stall   = bus.id_valid & ~bus.flush & hazard;
  assign advance = bus.id_valid & ~bus.flush & ~stall;

  always_comb begin
    ex_d    = '0;
    sel_a_d = OPSEL_REG;
    sel_b_d = OPSEL_REG;
    state_d = stall ? ST_STALL : ST_RUN;
    if (advance) begin
      ex_d.vld = 1'b1;
      ex_d.rd  = bus.id_rd;
      ex_d.wr  = bus.id_reg_write;
      ex_d.ld  = bus.id_mem_read;
      sel_a_d  = pick_sel(bus.id_a_pc,  hit[0], hit[2], FWD_EN);
      sel_b_d  = pick_sel(bus.id_b_imm, hit[1], hit[3], FWD_EN);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q     <= '0;
      mem_q    <= '0;
      state_q  <= ST_RUN;
      sel_a_q  <= OPSEL_REG;
      sel_b_q  <= OPSEL_REG;
      bubble_q <= 1'b1;
      count_q  <= '0;
    end else begin
      mem_q    <= ex_to_mem(ex_q);
      ex_q     <= ex_d;
      state_q  <= state_d;
      sel_a_q  <= sel_a_d;
      sel_b_q  <= sel_b_d;
      bubble_q <= ~advance;
      if (stall && (count_q != '1)) begin
        count_q <= count_q + DATA_WIDTH'(1);
      end
    end
  end

  assign bus.stall       = stall;
  assign bus.ex_bubble   = bubble_q;
  assign bus.fwd_a_sel   = sel_a_q;
  assign bus.fwd_b_sel   = sel_b_q;
  assign bus.stall_count = count_q;

endmodule

// File: tb/tb_alu_operand_ctrl.sv
// Self-checking bench for alu_operand_ctrl: directed vector table, reset-mid-stall
// sequence and randomized traffic against a pipeline-history reference model.
module tb_alu_operand_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  alu_operand_ctrl_if #(.REGADDR_WIDTH(5), .DATA_WIDTH(32)) bus ();

  alu_operand_ctrl #(.DATA_WIDTH(32), .REGADDR_WIDTH(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int tests = 0;
  int fails = 0;

  typedef struct {
    int v, rs1, rs2, u1, u2, rd, wr, ld, apc, bimm, fl;
    int e_stall, e_bub, e_sa, e_sb, e_cnt;
  } vec_t;

`ifdef ALU_FWD_EN
  localparam bit TB_FWD = 1'b1;
  localparam int NV = 17;
`else
  localparam bit TB_FWD = 1'b0;
  localparam int NV = 12;
`endif
  vec_t tbl [NV];

  typedef struct {
    bit       vld;
    bit [4:0] rd;
    bit       wr;
    bit       ld;
  } rec_t;
  rec_t m_ex, m_mem;
  longint m_cnt;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    bus.id_valid     = v.v[0];
    bus.id_rs1       = v.rs1[4:0];
    bus.id_rs2       = v.rs2[4:0];
    bus.id_use_rs1   = v.u1[0];
    bus.id_use_rs2   = v.u2[0];
    bus.id_rd        = v.rd[4:0];
    bus.id_reg_write = v.wr[0];
    bus.id_mem_read  = v.ld[0];
    bus.id_a_pc      = v.apc[0];
    bus.id_b_imm     = v.bimm[0];
    bus.flush        = v.fl[0];
  endtask

  function automatic vec_t idle_vec();
    vec_t v;
    v = '{0,0,0,0,0,0,0,0,0,0,0, 0,1,0,0,0};
    return v;
  endfunction

  function automatic bit raw(input rec_t r, input int rs, input bit use_rs);
    return r.vld && r.wr && (int'(r.rd) == rs) && (rs != 0) && use_rs;
  endfunction

  // Reference: the spec's rules over the two most recent issued instructions.
  task automatic rand_cycle(input int idx);
    vec_t v;
    bit ua, ub, hae, hbe, ham, hbm, est, adv;
    int esa, esb;
    v = idle_vec();
    v.v    = ($urandom_range(0, 9) < 8) ? 1 : 0;
    v.rs1  = $urandom_range(0, 3);
    v.rs2  = $urandom_range(0, 3);
    v.rd   = $urandom_range(0, 3);
    v.u1   = $urandom_range(0, 1);
    v.u2   = $urandom_range(0, 1);
    v.wr   = ($urandom_range(0, 3) != 0) ? 1 : 0;
    v.ld   = ($urandom_range(0, 9) < 3) ? 1 : 0;
    v.apc  = ($urandom_range(0, 19) < 3) ? 1 : 0;
    v.bimm = ($urandom_range(0, 4) == 0) ? 1 : 0;
    v.fl   = ($urandom_range(0, 9) == 0) ? 1 : 0;
    ua  = v.u1[0] && !v.apc[0];
    ub  = v.u2[0] && !v.bimm[0];
    hae = raw(m_ex,  v.rs1, ua);
    hbe = raw(m_ex,  v.rs2, ub);
    ham = raw(m_mem, v.rs1, ua);
    hbm = raw(m_mem, v.rs2, ub);
    if (TB_FWD) est = v.v[0] && !v.fl[0] && m_ex.ld && (hae || hbe);
    else        est = v.v[0] && !v.fl[0] && (hae || hbe || ham || hbm);
    adv = v.v[0] && !v.fl[0] && !est;
    esa = 0;
    esb = 0;
    if (adv) begin
      esa = v.apc[0]  ? 3 : (TB_FWD ? (hae ? 1 : (ham ? 2 : 0)) : 0);
      esb = v.bimm[0] ? 3 : (TB_FWD ? (hbe ? 1 : (hbm ? 2 : 0)) : 0);
    end
    apply(v);
    #1;
    chk($sformatf("rand%0d.stall", idx), 64'(bus.stall), 64'(est));
    @(posedge clk);
    #1;
    m_mem = '{m_ex.vld, m_ex.rd, m_ex.wr, 1'b0};
    if (adv) m_ex = '{1'b1, v.rd[4:0], v.wr[0], v.ld[0]};
    else     m_ex = '{1'b0, 5'd0, 1'b0, 1'b0};
    if (est && m_cnt != 64'hFFFF_FFFF) m_cnt++;
    chk($sformatf("rand%0d.ex_bubble", idx), 64'(bus.ex_bubble), 64'(!adv));
    chk($sformatf("rand%0d.fwd_a_sel", idx), 64'(bus.fwd_a_sel), 64'(esa));
    chk($sformatf("rand%0d.fwd_b_sel", idx), 64'(bus.fwd_b_sel), 64'(esb));
    chk($sformatf("rand%0d.stall_count", idx), 64'(bus.stall_count), 64'(m_cnt));
  endtask

  initial begin
    vec_t lw_v, use_v;
`ifdef ALU_FWD_EN
    tbl = '{
      '{1, 1, 2,1,1, 5,1,0,0,0,0, 0,0,0,0,0},  // add x5 <- x1,x2
      '{1, 5, 3,1,1, 6,1,0,0,0,0, 0,0,1,0,0},  // sub x6 <- x5,x3 : A from EX/MEM
      '{1, 1, 2,1,1,10,1,0,0,0,0, 0,0,0,0,0},  // add x10
      '{0, 0, 0,0,0, 0,0,0,0,0,0, 0,1,0,0,0},  // nop
      '{1, 4,10,1,1, 7,1,0,0,0,0, 0,0,0,2,0},  // or x7 <- x4,x10 : B from MEM/WB
      '{1, 1, 0,1,0, 8,1,1,0,0,0, 0,0,0,0,0},  // lw x8
      '{1, 8, 8,1,1, 9,1,0,0,0,0, 1,1,0,0,1},  // add x9 <- x8,x8 : load-use stall
      '{1, 8, 8,1,1, 9,1,0,0,0,0, 0,0,2,2,1},  // same add advances, both MEM/WB
      '{1, 1, 0,1,0, 0,1,0,0,1,0, 0,0,0,3,1},  // addi x0, imm
      '{1, 0, 0,1,1, 3,1,0,0,0,0, 0,0,0,0,1},  // add x3 <- x0,x0
      '{1, 3, 3,1,1, 4,1,0,0,1,0, 0,0,1,3,1},  // imm overrides EX match on B
      '{1, 1, 0,1,0,12,1,1,0,0,0, 0,0,0,0,1},  // lw x12
      '{1,12, 2,1,1,13,1,0,0,0,1, 0,1,0,0,1},  // load-use with flush
      '{0, 0, 0,0,0, 0,0,0,0,0,0, 0,1,0,0,1},
      '{1, 1, 1,1,1, 5,1,0,0,0,0, 0,0,0,0,1},  // add x5
      '{1, 5, 1,1,1, 5,1,0,0,0,0, 0,0,1,0,1},  // add x5 <- x5
      '{1, 5, 5,1,1, 6,1,0,0,0,0, 0,0,1,1,1}   // EX and MEM both x5 : EX wins
    };
`else
    tbl = '{
      '{1, 1, 2,1,1, 5,1,0,0,0,0, 0,0,0,0,0},  // add x5 <- x1,x2
      '{1, 5, 3,1,1, 6,1,0,0,0,0, 1,1,0,0,1},  // sub x6 <- x5 : stall 1
      '{1, 5, 3,1,1, 6,1,0,0,0,0, 1,1,0,0,2},  // stall 2
      '{1, 5, 3,1,1, 6,1,0,0,0,0, 0,0,0,0,2},  // producer in WB : advance
      '{1, 6, 1,1,1, 3,1,0,1,1,0, 0,0,3,3,2},  // PC/imm overrides suppress
      '{1, 0, 0,1,1, 4,1,0,0,0,0, 0,0,0,0,2},
      '{1, 1, 0,1,0, 8,1,1,0,0,0, 0,0,0,0,2},  // lw x8
      '{1, 8, 8,1,1, 9,1,0,0,0,1, 0,1,0,0,2},  // flush wins over stall
      '{1, 2, 8,1,1, 9,1,0,0,0,0, 1,1,0,0,3},  // MEM match stalls
      '{1, 2, 8,1,1, 9,1,0,0,0,0, 0,0,0,0,3},
      '{1, 1, 0,1,0, 0,1,0,0,1,0, 0,0,0,3,3},  // addi x0, imm
      '{1, 0, 0,1,1, 3,1,0,0,0,0, 0,0,0,0,3}   // add <- x0 : no hazard
    };
`endif
    rst_n = 1'b0;
    apply(idle_vec());
    repeat (2) @(posedge clk);
    #1;
    chk("reset.stall",       64'(bus.stall),       64'd0);
    chk("reset.ex_bubble",   64'(bus.ex_bubble),   64'd1);
    chk("reset.fwd_a_sel",   64'(bus.fwd_a_sel),   64'd0);
    chk("reset.fwd_b_sel",   64'(bus.fwd_b_sel),   64'd0);
    chk("reset.stall_count", 64'(bus.stall_count), 64'd0);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      apply(tbl[i]);
      #1;
      chk($sformatf("vec%0d.stall", i), 64'(bus.stall), 64'(tbl[i].e_stall));
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d.ex_bubble", i),   64'(bus.ex_bubble),   64'(tbl[i].e_bub));
      chk($sformatf("vec%0d.fwd_a_sel", i),   64'(bus.fwd_a_sel),   64'(tbl[i].e_sa));
      chk($sformatf("vec%0d.fwd_b_sel", i),   64'(bus.fwd_b_sel),   64'(tbl[i].e_sb));
      chk($sformatf("vec%0d.stall_count", i), 64'(bus.stall_count), 64'(tbl[i].e_cnt));
    end

    // Reset asserted while a hazard stall is active.
    apply(idle_vec());
    repeat (2) @(posedge clk);
    #1;
    lw_v  = '{1,1,0,1,0,8,1,1,0,0,0, 0,0,0,0,0};
    use_v = '{1,8,8,1,1,9,1,0,0,0,0, 0,0,0,0,0};
    apply(lw_v);
    @(posedge clk);
    #1;
    apply(use_v);
    #1;
    chk("rstmid.stall_before", 64'(bus.stall), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("rstmid.stall",       64'(bus.stall),       64'd0);
    chk("rstmid.ex_bubble",   64'(bus.ex_bubble),   64'd1);
    chk("rstmid.fwd_a_sel",   64'(bus.fwd_a_sel),   64'd0);
    chk("rstmid.stall_count", 64'(bus.stall_count), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    chk("rstmid.no_replay", 64'(bus.stall), 64'd0);
    apply(idle_vec());
    @(posedge clk);
    #1;
    chk("rstmid.bubble_after", 64'(bus.ex_bubble), 64'd1);

    // Randomized traffic from a clean reset.
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    m_ex  = '{1'b0, 5'd0, 1'b0, 1'b0};
    m_mem = '{1'b0, 5'd0, 1'b0, 1'b0};
    m_cnt = 0;
    for (int i = 0; i < 400; i++) begin
      rand_cycle(i);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_operand_ctrl.md
# alu_operand_ctrl

Pipeline hazard and forwarding controller for the RV32I core. It tracks the destination registers of the instructions in EX and MEM and drives the 2-bit select lines of the two EX-stage ALU operand muxes (A and B). It detects load-use hazards and issues a one-cycle stall with a bubble inserted into EX. It sits between the ID/EX pipeline register and the ALU operand muxes.

## Interface
- DATA_WIDTH, 32: width of the stall performance counter.
- REGADDR_WIDTH, 5: register address width.

- clk  in  1  core clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- id_valid  in  1  ID holds a valid instruction.
- id_rs1, id_rs2  in  REGADDR_WIDTH  source registers of the ID instruction.
- id_use_rs1, id_use_rs2  in  1  the instruction actually reads rs1 / rs2.
- id_rd  in  REGADDR_WIDTH  destination register of the ID instruction.
- id_reg_write  in  1  the ID instruction writes rd.
- id_mem_read  in  1  the ID instruction is a load.
- id_a_pc, id_b_imm  in  1  decoder requests PC as operand A / immediate as operand B.
- flush  in  1  branch/jump redirect: kill the ID instruction.
- stall  out  1  hold PC, IF/ID; combinational.
- ex_bubble  out  1  registered; the EX slot is a NOP this cycle.
- fwd_a_sel, fwd_b_sel  out  2  registered operand-mux selects for the EX instruction: 00 regfile, 01 EX/MEM result, 10 MEM/WB result, 11 PC (A) or immediate (B).
- stall_count  out  DATA_WIDTH  saturating count of stall cycles.

## Operation
- Internal stage records: EX {vld, rd, wr, ld} and MEM {vld, rd, wr}. Every cycle EX shifts into MEM unconditionally.
- ID→EX advance happens when `id_valid & !stall & !flush`. Otherwise EX is loaded with a bubble (vld=0), and ex_bubble=1 on the next cycle.
- A RAW match on an EX or MEM record requires vld & wr & rd==rs & rd!=0 & use_rsX. x0 never matches.
- Select computation in ID, latched on advance:
  - An operand override (id_a_pc / id_b_imm) gives 11. It takes priority and suppresses the hazard check for that operand.
  - Otherwise, a match on the EX record gives 01. The producer will be in MEM when the consumer reaches EX.
  - Otherwise, a match on the MEM record gives 10.
  - Otherwise the select is 00.
  - The register file is write-before-read, so WB needs no forwarding.
- Load-use: if the EX record has ld=1 and matches either used source, stall=1 for one cycle. On the next cycle the load sits in MEM, the match resolves to 10, and the instruction advances.
- FSM states:
  - RUN → STALL on a load-use hazard with flush=0.
  - STALL → RUN once no hazard remains. With FWD_EN, STALL always lasts exactly one cycle.
- flush has priority over stall: stall=0, the ID instruction is discarded, EX gets a bubble, and the FSM goes to RUN.
- stall_count increments on every cycle with stall=1 and saturates at all-ones.
- When the EX slot is a bubble, both selects are 00.

## Timing
- Reset values: the FSM is in RUN, all stage records are invalid, fwd_a_sel=fwd_b_sel=00, ex_bubble=1, stall_count=0. stall is 0 because the records are invalid.
- stall is combinational from the ID inputs and the EX/MEM records, and is valid in the same cycle.
- Select latency: one cycle. The selects are computed in ID and presented with the instruction in EX.
- Reset mid-stall: the stall is aborted, all records are cleared, and nothing is replayed. IF re-fetches after reset.
- Simultaneous match on EX and MEM for the same register: EX (01) wins, because it is the youngest producer.

## Configuration
- ALU_FWD_EN defined: forwarding operates as described above.
- ALU_FWD_EN undefined: selects are only 00 or 11. Any RAW match on EX or MEM stalls. A stall lasts up to 2 cycles and ends when the producer has reached WB. Loads are not special-cased.

## Structure
- Shared package core_pkg holds:
  - the operand select encodings OPSEL_REG, OPSEL_EXMEM, OPSEL_MEMWB, OPSEL_ALT;
  - the FSM state encoding RUN/STALL;
  - the stage-record typedef.
- One sub-module, raw_match: purely combinational comparator (rs, use, record) → hit. It is instantiated four times (rs1/rs2 × EX/MEM).

## Test plan
- Dependent ALU ops (add x5 ← x1,x2; then sub x6 ← x5,x3): fwd_a_sel=01 in the sub's EX cycle, no stall.
- Distance-2 dependency (add x5; nop; or x7 ← x4,x5): fwd_b_sel=10 in the or's EX cycle.
- Load-use (lw x8; add x9 ← x8,x8): stall=1 for exactly one cycle. Then ex_bubble=1, both selects=10 for the add, and stall_count=1.
- x0 producer (addi x0; add ← x0): selects 00, no stall. id_b_imm=1 with rs2 matching EX gives fwd_b_sel=11.
- flush asserted during a load-use stall: stall drops in the same cycle, EX gets a bubble, FSM is in RUN.
- ALU_FWD_EN undefined, dependent ALU ops back-to-back: stall=1 for 2 cycles, then selects 00 and stall_count=2.
